// File: rtl/fifo512_ctrl.sv
// Byte FIFO controller for a 512x8 dual-port synchronous RAM.
// Tracks the pointers, fill level and sticky errors, and sequences the RAM ports.
module fifo512_ctrl #(
    parameter int AFULL_LVL  = 448,
    parameter int AEMPTY_LVL = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       wr_stb,
    input  logic [7:0] wr_data,
    input  logic       rd_stb,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       full,
    output logic       empty,
    output logic       afull,
    output logic       aempty,
    output logic [9:0] level,
    output logic       err_ovf,
    output logic       err_udf,
    output logic       mem_we,
    output logic [8:0] mem_wraddr,
    output logic [7:0] mem_datain,
    output logic       mem_re,
    output logic [8:0] mem_rdaddr,
    input  logic [7:0] mem_dataout
);

    localparam logic [9:0] AFULL_L  = 10'(AFULL_LVL);
    localparam logic [9:0] AEMPTY_L = 10'(AEMPTY_LVL);
    localparam logic [9:0] DEPTH    = 10'd512;

    logic [8:0] wr_ptr;
    logic [8:0] rd_ptr;
    logic       wa;
    logic       ra;

    assign full   = (level == DEPTH);
    assign empty  = (level == 10'd0);
    assign afull  = (level >= AFULL_L);
    assign aempty = (level <= AEMPTY_L);

    // Accept decisions use the pre-edge level; the rst_n term keeps the
    // RAM ports quiet while reset is held.
    assign wa = wr_stb & ~full & ~flush & rst_n;
    assign ra = rd_stb & ~empty & ~flush & rst_n;

    assign mem_we     = wa;
    assign mem_wraddr = wr_ptr;
    assign mem_datain = wr_data;
    assign mem_re     = ra;
    assign mem_rdaddr = rd_ptr;
    assign rd_data    = mem_dataout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else begin
            // 9-bit pointers wrap from 511 to 0 on their own.
            if (wa) wr_ptr <= wr_ptr + 9'd1;
            if (ra) rd_ptr <= rd_ptr + 9'd1;
            rd_valid <= ra;
            if (wa && !ra)
                level <= level + 10'd1;
            else if (ra && !wa)
                level <= level - 10'd1;
            if (wr_stb && full)  err_ovf <= 1'b1;
            if (rd_stb && empty) err_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo512_ctrl.sv
// Directed bench for fifo512_ctrl: a vector table from reset, then
// hand-written sequences for fill, drain, streaming, flush and async reset.
module tb_fifo512_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_stb;
    logic [7:0] wr_data;
    logic       rd_stb;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full, empty, afull, aempty;
    logic [9:0] level;
    logic       err_ovf, err_udf;
    logic       mem_we, mem_re;
    logic [8:0] mem_wraddr, mem_rdaddr;
    logic [7:0] mem_datain, mem_dataout;

    logic [7:0] ram [512];

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    fifo512_ctrl #(.AFULL_LVL(448), .AEMPTY_LVL(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_stb(wr_stb), .wr_data(wr_data), .rd_stb(rd_stb),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .afull(afull), .aempty(aempty),
        .level(level), .err_ovf(err_ovf), .err_udf(err_udf),
        .mem_we(mem_we), .mem_wraddr(mem_wraddr), .mem_datain(mem_datain),
        .mem_re(mem_re), .mem_rdaddr(mem_rdaddr), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // Behavioural 512x8 RAM with registered read data.
    always @(posedge clk) begin
        if (mem_we) ram[mem_wraddr] <= mem_datain;
        if (mem_re) mem_dataout <= ram[mem_rdaddr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic fl, input logic wr, input logic [7:0] wd, input logic rd);
        flush   = fl;
        wr_stb  = wr;
        wr_data = wd;
        rd_stb  = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       fl;
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       we;
        logic       re;
        logic [9:0] lvl;
        logic       emp;
        logic       rv;
        logic [7:0] rdat;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs [12];
    logic [7:0] d;
    logic [7:0] e;

    initial begin
        //          fl wr wd     rd we re lvl emp rv rdat   ovf udf
        vecs[0]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1};
        vecs[1]  = '{0, 1, 8'h11, 1, 1, 0, 1, 0, 0, 8'h00, 0, 1};
        vecs[2]  = '{0, 1, 8'h22, 1, 1, 1, 1, 0, 1, 8'h11, 0, 1};
        vecs[3]  = '{0, 0, 8'h00, 1, 0, 1, 0, 1, 1, 8'h22, 0, 1};
        vecs[4]  = '{1, 1, 8'h99, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0};
        vecs[5]  = '{0, 1, 8'h33, 0, 1, 0, 1, 0, 0, 8'h00, 0, 0};
        vecs[6]  = '{0, 1, 8'h44, 0, 1, 0, 2, 0, 0, 8'h00, 0, 0};
        vecs[7]  = '{0, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'h33, 0, 0};
        vecs[8]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0};
        vecs[9]  = '{0, 0, 8'h00, 1, 0, 1, 0, 1, 1, 8'h44, 0, 0};
        vecs[10] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1};
        vecs[11] = '{1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0};

        rst_n = 1'b0;
        set_in(0, 0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_aempty", aempty, 1);
        chk("rst_afull", afull, 0);
        chk("rst_rv", rd_valid, 0);
        chk("rst_errs", {err_ovf, err_udf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: one vector per cycle, combinational ports before the edge,
        // registered state after it.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].fl, vecs[i].wr, vecs[i].wd, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_we", i), mem_we, vecs[i].we);
            chk($sformatf("v%0d_re", i), mem_re, vecs[i].re);
            step();
            chk($sformatf("v%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].emp);
            chk($sformatf("v%0d_rv", i), rd_valid, vecs[i].rv);
            if (vecs[i].rv) chk($sformatf("v%0d_rdata", i), rd_data, vecs[i].rdat);
            chk($sformatf("v%0d_ovf", i), err_ovf, vecs[i].ovf);
            chk($sformatf("v%0d_udf", i), err_udf, vecs[i].udf);
        end
        set_in(0, 0, 8'h00, 0);

        // Fresh reset, then fill to 512.
        rst_n = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 512; i++) begin
            set_in(0, 1, i[7:0], 0);
            exp_q.push_back(i[7:0]);
            step();
            chk("fill_level", level, i + 1);
            chk("fill_afull", afull, (i + 1 >= 448) ? 1 : 0);
            chk("fill_aempty", aempty, (i + 1 <= 64) ? 1 : 0);
        end
        chk("fill_full", full, 1);
        set_in(0, 1, 8'hEE, 0);
        #1;
        chk("ovf_we", mem_we, 0);
        step();
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_level", level, 512);

        // Full with simultaneous read and write: only the read goes through.
        set_in(0, 1, 8'hEE, 1);
        #1;
        chk("fullrw_we", mem_we, 0);
        chk("fullrw_re", mem_re, 1);
        step();
        e = exp_q.pop_front();
        chk("fullrw_level", level, 511);
        chk("fullrw_ovf", err_ovf, 1);
        chk("fullrw_rv", rd_valid, 1);
        chk("fullrw_rdata", rd_data, e);

        for (int i = 0; i < 511; i++) begin
            set_in(0, 0, 8'h00, 1);
            step();
            e = exp_q.pop_front();
            chk("drain_rv", rd_valid, 1);
            chk("drain_rdata", rd_data, e);
        end
        set_in(0, 0, 8'h00, 0);
        step();
        chk("drain_empty", empty, 1);
        chk("drain_rv_end", rd_valid, 0);
        set_in(0, 0, 8'h00, 1);
        #1;
        chk("udf_re", mem_re, 0);
        step();
        set_in(0, 0, 8'h00, 0);
        chk("udf_flag", err_udf, 1);
        chk("udf_rv", rd_valid, 0);

        // Clear, then empty with simultaneous read and write.
        set_in(1, 0, 8'h00, 0);
        step();
        chk("flush_udf", err_udf, 0);
        set_in(0, 1, 8'h77, 1);
        #1;
        chk("emptyrw_we", mem_we, 1);
        chk("emptyrw_re", mem_re, 0);
        exp_q.push_back(8'h77);
        step();
        set_in(0, 0, 8'h00, 0);
        chk("emptyrw_level", level, 1);
        chk("emptyrw_udf", err_udf, 1);
        chk("emptyrw_rv", rd_valid, 0);

        // Streaming at level 3 across many pointer wraps.
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 8'(8'hC0 + i), 0);
            exp_q.push_back(8'(8'hC0 + i));
            step();
        end
        chk("stream_start_level", level, 3);
        for (int i = 0; i < 2000; i++) begin
            d = 8'($urandom_range(0, 255));
            set_in(0, 1, d, 1);
            exp_q.push_back(d);
            step();
            e = exp_q.pop_front();
            chk("stream_rv", rd_valid, 1);
            chk("stream_rdata", rd_data, e);
            chk("stream_level", level, 3);
        end

        // Flush at level 100 right after an accepted read.
        for (int i = 0; i < 97; i++) begin
            set_in(0, 1, i[7:0], 0);
            exp_q.push_back(i[7:0]);
            step();
        end
        chk("pre_flush_level", level, 100);
        set_in(0, 0, 8'h00, 1);
        step();
        e = exp_q.pop_front();
        set_in(1, 1, 8'h99, 1);
        #1;
        chk("flushcyc_rv", rd_valid, 1);
        chk("flushcyc_rdata", rd_data, e);
        chk("flushcyc_we", mem_we, 0);
        chk("flushcyc_re", mem_re, 0);
        step();
        exp_q.delete();
        chk("postflush_level", level, 0);
        chk("postflush_empty", empty, 1);
        chk("postflush_errs", {err_ovf, err_udf}, 0);
        chk("postflush_rv", rd_valid, 0);
        set_in(0, 1, 8'hA5, 0);
        step();
        set_in(0, 0, 8'h00, 1);
        step();
        set_in(0, 0, 8'h00, 0);
        chk("a5_rv", rd_valid, 1);
        chk("a5_rdata", rd_data, 8'hA5);

        // Asynchronous reset between edges with traffic in flight.
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 1, i[7:0], 0);
            step();
        end
        set_in(0, 0, 8'h00, 1);
        step();
        set_in(0, 1, 8'h04, 0);
        chk("prearst_rv", rd_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_aempty", aempty, 1);
        chk("arst_afull", afull, 0);
        chk("arst_rv", rd_valid, 0);
        chk("arst_errs", {err_ovf, err_udf}, 0);
        chk("arst_we", mem_we, 0);
        chk("arst_re", mem_re, 0);
        @(negedge clk);
        set_in(0, 0, 8'h00, 0);
        rst_n = 1'b1;
        set_in(0, 1, 8'h5A, 0);
        step();
        chk("postrst_level", level, 1);
        set_in(0, 0, 8'h00, 1);
        step();
        set_in(0, 0, 8'h00, 0);
        chk("postrst_rv", rd_valid, 1);
        chk("postrst_rdata", rd_data, 8'h5A);
        chk("postrst_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
